// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types and helpers for the instruction cache.
//   icache_state_t : controller states (IDLE waits for lookups, FILL streams
//                    a missing block in from memory)
//   log2ceil       : ceiling log2 used to size address fields
//   wordBits       : width of the word-offset field for a block size
//   indexBits      : width of the set-index field for a set count
//   tagBits        : width of the tag left over from a 32-bit byte address
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // Smallest r with (1 << r) >= n; returns 0 for n <= 1.
    function automatic int log2ceil(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int wordBits(input int words);
        return log2ceil(words);
    endfunction

    function automatic int indexBits(input int nsets);
        return log2ceil(nsets);
    endfunction

    // Two byte-offset bits are always dropped before the word offset.
    function automatic int tagBits(input int nsets, input int words);
        return 30 - log2ceil(words) - log2ceil(nsets);
    endfunction

endpackage

// File: rtl/icache_satcnt.sv
// ---------------------------------------------------------------------------
// icache_satcnt
// Up-counter that sticks at its all-ones value instead of wrapping.
//   CLK   : clock, counts on rising edge
//   RST   : asynchronous active-high reset, clears the count
//   inc   : count one event this cycle
//   count : current value
// ---------------------------------------------------------------------------
module icache_satcnt #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Increment only while headroom remains so the count pins at all-ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/icache_param.sv
// ---------------------------------------------------------------------------
// icache_param
// Direct-mapped, blocking instruction cache with a whole-cache invalidate.
//   CLK, RST           : clock and asynchronous active-high reset
//   imemREN, imemaddr  : datapath fetch request and byte address
//   ihit, imemload     : same-cycle hit indication and instruction word
//   iREN, iaddr        : memory read request and word address during a fill
//   iwait, iload       : memory busy flag and returned read data
//   inval              : one-cycle pulse clearing every valid bit
//   hit_cnt, miss_cnt  : saturating hit / miss statistics
// ---------------------------------------------------------------------------
module icache_param
    import cpu_types_pkg::*;
#(
    parameter int NSETS = 16,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    input  logic        inval,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int WB   = wordBits(WORDS);
    localparam int IB   = indexBits(NSETS);
    localparam int TB   = tagBits(NSETS, WORDS);
    localparam int CW   = (WB == 0) ? 1 : WB;
    localparam int OFS  = 2 + WB;
    localparam int TOFS = 2 + WB + IB;

    icache_state_t  state;
    logic [CW-1:0]  fillCnt;
    logic [NSETS-1:0] validBits;
    logic [TB-1:0]  tagArr  [NSETS];
    logic [31:0]    dataArr [NSETS][WORDS];

    logic [IB-1:0]  missIndex;
    logic [TB-1:0]  missTag;

    logic [CW-1:0]  reqWord;
    logic [IB-1:0]  reqIndex;
    logic [TB-1:0]  reqTag;
    logic           tagMatch;
    logic           lookupHit;
    logic           lookupMiss;
    logic           fillBeat;
    logic           fillDone;

    // Fields are extracted with shifts so a one-word block (no word offset)
    // needs no zero-width slice.
    assign reqWord  = CW'((imemaddr >> 2) & 32'(WORDS - 1));
    assign reqIndex = IB'(imemaddr >> OFS);
    assign reqTag   = TB'(imemaddr >> TOFS);

    // Lookups only happen in IDLE; an inval in the same cycle still sees the
    // old contents because the valid bits only clear at the edge.
    assign tagMatch   = validBits[reqIndex] && (tagArr[reqIndex] == reqTag);
    assign lookupHit  = (state == IDLE) && imemREN && tagMatch;
    assign lookupMiss = (state == IDLE) && imemREN && !tagMatch;
    assign ihit       = lookupHit;
    assign imemload   = lookupHit ? dataArr[reqIndex][reqWord] : 32'd0;

    // Memory side is driven straight from the state register, so an async
    // reset drops iREN without waiting for an edge.
    assign fillBeat = (state == FILL) && !iwait;
    assign fillDone = fillBeat && (fillCnt == CW'(WORDS - 1));
    assign iREN     = (state == FILL);
    assign iaddr    = (state == FILL) ?
                      ((32'(missTag) << TOFS) | (32'(missIndex) << OFS) |
                       (32'(fillCnt) << 2)) : 32'd0;

    // Controller: inval beats everything, including a fill finishing in the
    // same cycle, so an abandoned set never becomes valid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            fillCnt   <= '0;
            validBits <= '0;
        end else if (inval) begin
            state     <= IDLE;
            fillCnt   <= '0;
            validBits <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lookupMiss) begin
                        state   <= FILL;
                        fillCnt <= '0;
                    end
                end
                FILL: begin
                    if (fillBeat) begin
                        fillCnt <= fillCnt + 1'b1;
                    end
                    if (fillDone) begin
                        validBits[missIndex] <= 1'b1;
                        state                <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage and the latched miss address carry no reset; the valid bits
    // alone decide whether their contents mean anything.
    always_ff @(posedge CLK) begin
        if (lookupMiss) begin
            missIndex <= reqIndex;
            missTag   <= reqTag;
        end
        if (fillBeat && !inval) begin
            dataArr[missIndex][fillCnt] <= iload;
            if (fillDone) begin
                tagArr[missIndex] <= missTag;
            end
        end
    end

    icache_satcnt #(.WIDTH(32)) uHitCnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (lookupHit),
        .count (hit_cnt)
    );

    icache_satcnt #(.WIDTH(32)) uMissCnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (lookupMiss),
        .count (miss_cnt)
    );

endmodule

// File: tb/tb_icache_param.sv
// ---------------------------------------------------------------------------
// tb_icache_param
// Directed bench for icache_param with a behavioural memory and a queue of
// expected fetch words; also exercises a narrow icache_satcnt to reach the
// saturation point in a handful of cycles.
// ---------------------------------------------------------------------------
module tb_icache_param;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        inval;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    logic        satRst;
    logic        satInc;
    logic [2:0]  satCount;

    int checks;
    int failures;
    logic [31:0] expQ[$];
    logic [31:0] rdLog[$];

    // Memory contents are a fixed scramble of the word address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1) ^ 32'h0000_1234;
    endfunction

    assign iload = iwait ? 32'hDEAD_BEEF : memWord(iaddr);

    icache_param #(.NSETS(16), .WORDS(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .inval    (inval),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    icache_satcnt #(.WIDTH(3)) satDut (
        .CLK   (CLK),
        .RST   (satRst),
        .inc   (satInc),
        .count (satCount)
    );

    // 10-unit clock period, rising edges at 5, 15, 25, ...
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Log every completed memory read, sampled mid-cycle.
    always @(negedge CLK) begin
        if (iREN && !iwait) begin
            rdLog.push_back(iaddr);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic popCheck(input string tag);
        logic [31:0] exp;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_sbempty"}, 32'd1, 32'd0);
        end else begin
            exp = expQ.pop_front();
            checkOutput(tag, imemload, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue a fetch and hold it until ihit (bounded); returns the number of
    // non-hit cycles seen and whether iREN was low in the hit cycle.
    task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                 output int cycles, output logic renAtHit);
        imemREN  = 1'b1;
        imemaddr = addr;
        expQ.push_back(memWord(addr));
        cycles = 0;
        @(negedge CLK);
        while (!ihit && cycles < 20) begin
            @(negedge CLK);
            cycles++;
        end
        renAtHit = iREN;
        checkOutput({tag, "_ihit"}, 32'(ihit), 32'd1);
        popCheck({tag, "_data"});
        tick();
        imemREN = 1'b0;
    endtask

    initial begin
        int cyc;
        logic ren;
        logic [31:0] h0;
        logic [31:0] m0;

        checks   = 0;
        failures = 0;
        RST      = 1'b1;
        satRst   = 1'b1;
        satInc   = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'd0;
        iwait    = 1'b0;
        inval    = 1'b0;

        // Reset state.
        tick();
        tick();
        @(negedge CLK);
        checkOutput("rst_ihit", 32'(ihit), 32'd0);
        checkOutput("rst_iREN", 32'(iREN), 32'd0);
        checkOutput("rst_iaddr", iaddr, 32'd0);
        checkOutput("rst_imemload", imemload, 32'd0);
        checkOutput("rst_hit_cnt", hit_cnt, 32'd0);
        checkOutput("rst_miss_cnt", miss_cnt, 32'd0);
        tick();
        RST = 1'b0;
        tick();

        // Cold miss: two memory reads, then a hit on word 0.
        rdLog.delete();
        applyStimulus("cold40", 32'h0000_0040, cyc, ren);
        checkOutput("cold40_cycles", 32'(cyc), 32'd3);
        checkOutput("cold40_miss_cnt", miss_cnt, 32'd1);
        checkOutput("cold40_nreads", 32'(rdLog.size()), 32'd2);
        if (rdLog.size() == 2) begin
            checkOutput("cold40_rd0", rdLog[0], 32'h0000_0040);
            checkOutput("cold40_rd1", rdLog[1], 32'h0000_0044);
        end

        // Second word of the same block hits immediately.
        h0 = hit_cnt;
        applyStimulus("hit44", 32'h0000_0044, cyc, ren);
        checkOutput("hit44_cycles", 32'(cyc), 32'd0);
        checkOutput("hit44_iREN", 32'(ren), 32'd0);
        checkOutput("hit44_hit_delta", hit_cnt - h0, 32'd1);

        // Idle output when no request is present.
        @(negedge CLK);
        checkOutput("idle_imemload", imemload, 32'd0);
        checkOutput("idle_ihit", 32'(ihit), 32'd0);
        tick();

        // Conflict in set 8 evicts and refetches.
        applyStimulus("conf840", 32'h0000_0840, cyc, ren);
        checkOutput("conf840_cycles", 32'(cyc), 32'd3);
        applyStimulus("conf40", 32'h0000_0040, cyc, ren);
        checkOutput("conf40_cycles", 32'(cyc), 32'd3);
        checkOutput("conf_miss_cnt", miss_cnt, 32'd3);

        // Invalidate during the second cycle of a stalled fill.
        h0 = hit_cnt;
        m0 = miss_cnt;
        iwait    = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0100;
        tick();
        imemREN = 1'b0;
        checkOutput("inv_fill_iREN", 32'(iREN), 32'd1);
        checkOutput("inv_fill_iaddr", iaddr, 32'h0000_0100);
        tick();
        inval = 1'b1;
        tick();
        inval = 1'b0;
        checkOutput("inv_state_iREN", 32'(iREN), 32'd0);
        checkOutput("inv_hit_cnt", hit_cnt, h0);
        checkOutput("inv_miss_cnt", miss_cnt, m0 + 32'd1);
        iwait = 1'b0;
        applyStimulus("inv_reread", 32'h0000_0100, cyc, ren);
        checkOutput("inv_reread_cycles", 32'(cyc), 32'd3);

        // A lookup coinciding with inval uses the old contents, once.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0104;
        inval    = 1'b1;
        expQ.push_back(memWord(32'h0000_0104));
        @(negedge CLK);
        checkOutput("invsame_ihit", 32'(ihit), 32'd1);
        popCheck("invsame_data");
        tick();
        inval   = 1'b0;
        imemREN = 1'b0;
        applyStimulus("invsame_after", 32'h0000_0104, cyc, ren);
        checkOutput("invsame_after_cycles", 32'(cyc), 32'd3);

        // Asynchronous reset in the middle of a fill.
        iwait    = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0300;
        tick();
        imemREN = 1'b0;
        #1;
        checkOutput("rstfill_iREN_before", 32'(iREN), 32'd1);
        #1;
        RST = 1'b1;
        #1;
        checkOutput("rstfill_iREN", 32'(iREN), 32'd0);
        checkOutput("rstfill_iaddr", iaddr, 32'd0);
        checkOutput("rstfill_ihit", 32'(ihit), 32'd0);
        checkOutput("rstfill_imemload", imemload, 32'd0);
        checkOutput("rstfill_hit_cnt", hit_cnt, 32'd0);
        checkOutput("rstfill_miss_cnt", miss_cnt, 32'd0);
        tick();
        RST   = 1'b0;
        iwait = 1'b0;
        tick();
        applyStimulus("post_rst40", 32'h0000_0040, cyc, ren);
        checkOutput("post_rst40_cycles", 32'(cyc), 32'd3);
        checkOutput("post_rst40_miss_cnt", miss_cnt, 32'd1);

        // Saturation on a 3-bit counter: 6 counts, then 3 more pin at 7.
        satRst = 1'b0;
        satInc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        checkOutput("sat_preload", 32'(satCount), 32'd6);
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        satInc = 1'b0;
        checkOutput("sat_hold", 32'(satCount), 32'd7);

        checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
